// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN accelerator front-end.
// Image geometry and stream widths used by the loader and its word FIFO.
package cnn_pkg;

    localparam int PIX_W      = 16;
    localparam int WORD_W     = 64;
    localparam int ADDR_W     = 32;
    localparam int IMG_W      = 32;
    localparam int IMG_H      = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int LANES      = WORD_W / PIX_W;
    localparam int NPIX       = IMG_W * IMG_H;
    localparam int NWORDS     = NPIX / LANES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } loader_state_t;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/loader_word_fifo.sv
// Small synchronous word FIFO buffering the input stream ahead of the unpacker.
// Push while full is accepted only when a pop happens in the same cycle.
module loader_word_fifo
    import cnn_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = WORD_W,
    localparam int PTR_W = clog2_min1(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/input_image_loader.sv
// Input image loader: unpacks packed pixel words into one buffer write per cycle
// and signals the layer sequencer once a full image has been stored.
module input_image_loader
    import cnn_pkg::*;
#(
    parameter int                WORD_W     = cnn_pkg::WORD_W,
    parameter int                PIX_W      = cnn_pkg::PIX_W,
    parameter int                IMG_W      = cnn_pkg::IMG_W,
    parameter int                IMG_H      = cnn_pkg::IMG_H,
    parameter int                ADDR_W     = cnn_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = cnn_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              data_in_valid,
    input  logic [WORD_W-1:0] data_in,
    output logic              data_in_ready,
    output logic              buf_we_o,
    output logic [ADDR_W-1:0] buf_wr_addr_o,
    output logic [PIX_W-1:0]  buf_wr_data_o,
    output logic              busy_o,
    output logic              load_done_o,
    output logic              overflow_o
);

    localparam int LANES  = WORD_W / PIX_W;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NWORDS = NPIX / LANES;
    localparam int LANE_W = clog2_min1(LANES);
    localparam int WCNT_W = $clog2(NWORDS + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    loader_state_t     r_state;
    loader_state_t     w_state_next;
    logic              w_busy;
    logic              w_start_load;

    logic [WCNT_W-1:0] r_word_cnt;
    logic [WCNT_W-1:0] w_word_cnt_next;
    logic [ADDR_W-1:0] r_pix_cnt;
    logic              w_pix_last;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W-1:0]  w_fifo_count_next;
    logic [WORD_W-1:0] w_fifo_dout;
    logic              w_push;
    logic              w_pop;

    logic [WORD_W-1:0] r_word;
    logic              r_word_vld;
    logic [LANE_W-1:0] r_lane;
    logic              w_lane_last;
    logic              w_fire;
    logic [PIX_W-1:0]  w_lane_data;

    logic              r_ready;
    logic              r_ovf;
    logic              r_we;
    logic              r_we_last;
    logic              r_done;
    logic [ADDR_W-1:0] r_addr;
    logic [PIX_W-1:0]  r_data;

    loader_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data_in),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign w_push      = data_in_valid && r_ready && (!w_fifo_full || w_pop);
    assign w_lane_last = (r_lane == LANE_W'(LANES - 1));
    assign w_pop       = !w_fifo_empty && (!r_word_vld || w_lane_last);
    assign w_fire      = r_word_vld;
    assign w_pix_last  = (r_pix_cnt == ADDR_W'(NPIX - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start_i)                          w_state_next = ST_LOAD;
            ST_LOAD:  if (r_word_cnt == WCNT_W'(NWORDS))    w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_fire && w_pix_last)             w_state_next = ST_IDLE;
            default:                                        w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy       = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
        w_start_load = (r_state == ST_IDLE) && start_i;
    end

    // Ready is registered, so it is derived from next-cycle occupancy and word count.
    assign w_fifo_count_next = w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_word_cnt_next   = w_start_load ? '0 : r_word_cnt + WCNT_W'(w_push);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt <= '0;
            r_ready    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_word_cnt <= w_word_cnt_next;
            r_ready    <= (w_state_next == ST_LOAD)
                       && (w_fifo_count_next < CNT_W'(FIFO_DEPTH))
                       && (w_word_cnt_next < WCNT_W'(NWORDS));
            r_ovf      <= r_ovf || (data_in_valid && !r_ready);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word     <= '0;
            r_word_vld <= 1'b0;
            r_lane     <= '0;
        end else if (w_pop) begin
            r_word     <= w_fifo_dout;
            r_word_vld <= 1'b1;
            r_lane     <= '0;
        end else if (r_word_vld) begin
            if (w_lane_last) begin
                r_word_vld <= 1'b0;
                r_lane     <= '0;
            end else begin
                r_lane     <= r_lane + LANE_W'(1);
            end
        end
    end

    always_comb begin
        w_lane_data = r_word[PIX_W-1:0];
        for (int unsigned i = 0; i < LANES; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_lane_data = r_word[i*PIX_W +: PIX_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_we_last <= 1'b0;
            r_done    <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_pix_cnt <= '0;
        end else begin
            r_we      <= w_fire;
            r_we_last <= w_fire && w_pix_last;
            r_done    <= r_we_last;
            if (w_fire) begin
                r_addr <= BASE_ADDR + r_pix_cnt;
                r_data <= w_lane_data;
            end
            if (w_start_load) begin
                r_pix_cnt <= '0;
            end else if (w_fire) begin
                r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
            end
        end
    end

    assign data_in_ready = r_ready;
    assign buf_we_o      = r_we;
    assign buf_wr_addr_o = r_addr;
    assign buf_wr_data_o = r_data;
    assign busy_o        = w_busy;
    assign load_done_o   = r_done;
    assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_input_image_loader.sv
// Self-checking bench for input_image_loader: single-word vector table plus
// randomized full-image loads scored against an image-level reference model.
module tb_input_image_loader;

    localparam int NW = 256;
    localparam int NP = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        data_in_valid = 1'b0;
    logic [63:0] data_in = '0;
    logic        data_in_ready;
    logic        buf_we_o;
    logic [31:0] buf_wr_addr_o;
    logic [15:0] buf_wr_data_o;
    logic        busy_o;
    logic        load_done_o;
    logic        overflow_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [31:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          wc_q[$];
    logic [63:0] words [NW];

    typedef struct {
        logic [63:0] word;
        logic [15:0] pix [4];
    } vec_t;
    vec_t vecs [3];

    input_image_loader #(
        .BASE_ADDR (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .data_in_valid (data_in_valid),
        .data_in       (data_in),
        .data_in_ready (data_in_ready),
        .buf_we_o      (buf_we_o),
        .buf_wr_addr_o (buf_wr_addr_o),
        .buf_wr_data_o (buf_wr_data_o),
        .busy_o        (busy_o),
        .load_done_o   (load_done_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (buf_we_o === 1'b1) begin
            wa_q.push_back(buf_wr_addr_o);
            wd_q.push_back(buf_wr_data_o);
            wc_q.push_back(cyc);
        end
        if (load_done_o === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_i = 1'b0;
        data_in_valid = 1'b0;
        data_in = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        clr();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic gen_words();
        for (int i = 0; i < NW; i++) words[i] = {$urandom, $urandom};
    endtask

    // polite: valid only while ready is high; otherwise valid is held and overflow expected.
    task automatic send(input int n, input bit polite, input bit gaps, input int restart_at);
        int w;
        int g;
        bit want;
        w = 0;
        g = 0;
        while (w < n && g < 20000) begin
            want = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            start_i = (w == restart_at);
            data_in_valid = polite ? (want && data_in_ready) : want;
            data_in = words[w];
            if (data_in_valid && data_in_ready) w++;
            tick();
            g++;
        end
        data_in_valid = 1'b0;
        start_i = 1'b0;
        chk("send_words_accepted", 64'(w), 64'(n));
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (done_cnt == 0 && g < 3000) begin
            tick();
            g++;
        end
        repeat (8) tick();
    endtask

    task automatic check_image(input string tag, input bit full_speed);
        int n;
        int bad_a;
        int bad_d;
        logic [63:0] w;
        logic [15:0] exp_pix;
        n = wa_q.size();
        bad_a = 0;
        bad_d = 0;
        chk({tag, "_wr_count"}, 64'(n), 64'(NP));
        for (int k = 0; k < n; k++) begin
            w = words[(k / 4) % NW];
            exp_pix = w[16*(k%4) +: 16];
            if (wa_q[k] !== 32'(k)) begin
                if (bad_a == 0) $display("  %s first bad addr at write %0d: %0h", tag, k, wa_q[k]);
                bad_a++;
            end
            if (k >= NP || wd_q[k] !== exp_pix) bad_d++;
        end
        chk({tag, "_addr_mismatches"}, 64'(bad_a), 64'd0);
        chk({tag, "_data_mismatches"}, 64'(bad_d), 64'd0);
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        if (n >= NP) begin
            chk({tag, "_done_delay"}, 64'(done_cyc - wc_q[NP-1]), 64'd1);
            if (full_speed) chk({tag, "_write_span"}, 64'(wc_q[NP-1] - wc_q[0]), 64'(NP - 1));
        end
        chk({tag, "_busy_after"}, 64'(busy_o), 64'd0);
        chk({tag, "_ready_after"}, 64'(data_in_ready), 64'd0);
    endtask

    initial begin
        int g;
        int acc;
        vecs[0].word = 64'h0004_0003_0002_0001;
        vecs[0].pix  = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        vecs[1].word = 64'hFFFF_0000_8000_1234;
        vecs[1].pix  = '{16'h1234, 16'h8000, 16'h0000, 16'hFFFF};
        vecs[2].word = 64'hDEAD_BEEF_CAFE_F00D;
        vecs[2].pix  = '{16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD};

        do_reset();
        chk("rst_we", 64'(buf_we_o), 64'd0);
        chk("rst_addr", 64'(buf_wr_addr_o), 64'd0);
        chk("rst_data", 64'(buf_wr_data_o), 64'd0);
        chk("rst_ready", 64'(data_in_ready), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(load_done_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);

        // single-word vectors: lane order, addresses, latency
        for (int v = 0; v < 3; v++) begin
            do_reset();
            pulse_start();
            g = 0;
            while (!data_in_ready && g < 20) begin
                tick();
                g++;
            end
            chk("vec_ready", 64'(data_in_ready), 64'd1);
            data_in_valid = 1'b1;
            data_in = vecs[v].word;
            acc = cyc + 1;
            tick();
            data_in_valid = 1'b0;
            repeat (10) tick();
            chk("vec_nwrites", 64'(wa_q.size()), 64'd4);
            for (int k = 0; k < 4 && k < wa_q.size(); k++) begin
                chk("vec_addr", 64'(wa_q[k]), 64'(k));
                chk("vec_data", 64'(wd_q[k]), 64'(vecs[v].pix[k]));
                chk("vec_cycle", 64'(wc_q[k]), 64'(acc + 2 + k));
            end
            chk("vec_busy", 64'(busy_o), 64'd1);
            chk("vec_ovf", 64'(overflow_o), 64'd0);
        end

        // full image, valid every cycle
        do_reset();
        gen_words();
        pulse_start();
        send(NW, 1'b0, 1'b0, -1);
        wait_done();
        check_image("t2", 1'b1);
        chk("t2_ovf_from_throttle", 64'(overflow_o), 64'd1);

        // valid while idle
        do_reset();
        data_in_valid = 1'b1;
        data_in = 64'h1111_2222_3333_4444;
        repeat (5) tick();
        data_in_valid = 1'b0;
        repeat (20) tick();
        chk("t3_no_writes", 64'(wa_q.size()), 64'd0);
        chk("t3_ovf_set", 64'(overflow_o), 64'd1);
        chk("t3_busy", 64'(busy_o), 64'd0);
        do_reset();
        chk("t3_ovf_cleared", 64'(overflow_o), 64'd0);

        // reset mid-load, then a clean reload
        do_reset();
        gen_words();
        pulse_start();
        send(100, 1'b0, 1'b0, -1);
        #2 rst = 1'b1;
        #1;
        chk("t4_we", 64'(buf_we_o), 64'd0);
        chk("t4_addr", 64'(buf_wr_addr_o), 64'd0);
        chk("t4_data", 64'(buf_wr_data_o), 64'd0);
        chk("t4_ready", 64'(data_in_ready), 64'd0);
        chk("t4_busy", 64'(busy_o), 64'd0);
        chk("t4_done", 64'(load_done_o), 64'd0);
        chk("t4_ovf", 64'(overflow_o), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        clr();
        gen_words();
        pulse_start();
        send(NW, 1'b0, 1'b0, -1);
        wait_done();
        check_image("t4", 1'b1);

        // extra word after the image is complete
        do_reset();
        gen_words();
        pulse_start();
        send(NW, 1'b1, 1'b0, -1);
        chk("t5_ovf_before", 64'(overflow_o), 64'd0);
        chk("t5_ready_after_last", 64'(data_in_ready), 64'd0);
        data_in_valid = 1'b1;
        data_in = {$urandom, $urandom};
        tick();
        data_in_valid = 1'b0;
        chk("t5_ovf_after", 64'(overflow_o), 64'd1);
        wait_done();
        check_image("t5", 1'b0);

        // random gaps and a stray start in the middle of the load
        do_reset();
        gen_words();
        pulse_start();
        send(NW, 1'b1, 1'b1, 50);
        wait_done();
        check_image("t6", 1'b0);
        chk("t6_ovf", 64'(overflow_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
